// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: framed UART loader for the 16-bit program RAM.
// Verifies an XOR checksum, then releases the CPU through cpu_run.
`timescale 1ns/1ps
module prog_load_ctrl #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1_000_000,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          n_but,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [15:0]   mem_wdata,
  output logic          cpu_run,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state;
  logic          but_q;
  logic          press;
  logic          in_frame;
  logic [8:0]    n_words;
  logic [AW:0]   cnt;
  logic [7:0]    hi_q;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;
  logic [8:0]    len_n;
  logic [8:0]    cnt_nx;

  assign press    = but_q & ~n_but;
  assign in_frame = (state == S_LEN) || (state == S_HI) ||
                    (state == S_LO)  || (state == S_CSUM);
  assign len_n    = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
  assign cnt_nx   = 9'(cnt) + 9'd1;

  // Delayed button level; a 1->0 step is one press.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      but_q <= 1'b1;
    end else begin
      but_q <= n_but;
    end
  end

  // Frame parser: sequencing, write pulse, checksum and timeout.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      cpu_run      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      cnt          <= '0;
      hi_q         <= '0;
      csum         <= '0;
      tcnt         <= '0;
    end else begin
      mem_we <= 1'b0;
      if (in_frame && press) begin
        state <= S_IDLE;
        tcnt  <= '0;
      end else if (state == S_RUN) begin
        if (press) begin
          state   <= S_IDLE;
          cpu_run <= 1'b0;
        end
      end else if (in_frame && !rx_valid) begin
        if (tcnt == T_LAST) begin
          state    <= S_ERR;
          load_err <= 1'b1;
          tcnt     <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else if (rx_valid) begin
        tcnt <= '0;
        unique case (state)
          S_IDLE, S_ERR: begin
            if (rx_byte == SYNC) begin
              state    <= S_LEN;
              load_err <= 1'b0;
            end
          end
          S_LEN: begin
            if (len_n > DEPTH_W) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              state   <= S_HI;
              n_words <= len_n;
              cnt     <= '0;
              csum    <= rx_byte;
            end
          end
          S_HI: begin
            hi_q  <= rx_byte;
            csum  <= csum ^ rx_byte;
            state <= S_LO;
          end
          S_LO: begin
            mem_we    <= 1'b1;
            mem_waddr <= cnt[AW-1:0];
            mem_wdata <= {hi_q, rx_byte};
            csum      <= csum ^ rx_byte;
            cnt       <= cnt_nx[AW:0];
            state     <= (cnt_nx == n_words) ? S_CSUM : S_HI;
          end
          S_CSUM: begin
            if (rx_byte == csum) begin
              state        <= S_RUN;
              cpu_run      <= 1'b1;
              words_loaded <= n_words[AW:0];
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: frame-level model with an event scoreboard.
// Stimulus predicts events; a monitor pops them as the DUT shows them.
`timescale 1ns/1ps
module tb_prog_load_ctrl;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        n_but = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        cpu_run;
  logic        load_err;
  logic [8:0]  words_loaded;

  logic        s_n_but = 1'b1;
  logic        s_rx_valid = 1'b0;
  logic [7:0]  s_rx_byte = 8'h00;
  logic        s_mem_we;
  logic [3:0]  s_mem_waddr;
  logic [15:0] s_mem_wdata;
  logic        s_cpu_run;
  logic        s_load_err;
  logic [4:0]  s_words_loaded;
  bit          s_we_seen = 1'b0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_run = 1'b0;
  bit m_err = 1'b0;
  logic [15:0] fw[$];

  typedef enum int {EV_WR, EV_RUN_UP, EV_RUN_DN, EV_ERR_UP, EV_ERR_DN} ev_k;
  typedef struct {ev_k k; int a; int d; int c;} ev_t;
  ev_t exp_q[$];

  prog_load_ctrl #(.DEPTH(256), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .n_but(n_but),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  prog_load_ctrl #(.DEPTH(16), .TIMEOUT(TO)) dut_s (
    .clk(clk), .n_rst(n_rst), .n_but(s_n_but),
    .rx_valid(s_rx_valid), .rx_byte(s_rx_byte),
    .mem_we(s_mem_we), .mem_waddr(s_mem_waddr),
    .mem_wdata(s_mem_wdata), .cpu_run(s_cpu_run),
    .load_err(s_load_err), .words_loaded(s_words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (s_mem_we) s_we_seen = 1'b1;

  function void expect_ev(ev_k k, int a, int d, int c);
    ev_t e;
    e.k = k; e.a = a; e.d = d; e.c = c;
    exp_q.push_back(e);
  endfunction

  task automatic got(ev_k k, int a, int d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected %s a=%0d d=%h cyc=%0d", k.name(), a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.a != a || e.d != d || e.c != cyc) begin
        n_bad++;
        $display("FAIL event got %s a=%0d d=%h cyc=%0d, expected %s a=%0d d=%h cyc=%0d",
                 k.name(), a, d, cyc, e.k.name(), e.a, e.d, e.c);
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: turn output activity into events and check them.
  initial begin
    logic pr;
    logic pe;
    pr = 1'b0;
    pe = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (n_rst) begin
        if (mem_we) got(EV_WR, int'(mem_waddr), int'(mem_wdata));
        if (cpu_run && !pr) got(EV_RUN_UP, int'(words_loaded), 0);
        if (!cpu_run && pr) got(EV_RUN_DN, 0, 0);
        if (load_err && !pe) got(EV_ERR_UP, 0, 0);
        if (!load_err && pe) got(EV_ERR_DN, 0, 0);
      end
      pr = cpu_run;
      pe = load_err;
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] b);
    s_rx_valid = 1'b1;
    s_rx_byte  = b;
    @(posedge clk);
    #1;
    s_rx_valid = 1'b0;
  endtask

  task automatic press_btn();
    if (m_run) begin
      expect_ev(EV_RUN_DN, 0, 0, cyc + 1);
      m_run = 1'b0;
    end
    n_but = 1'b0;
    gap(1);
    n_but = 1'b1;
    gap(1);
  endtask

  task automatic sync_byte();
    if (m_err) begin
      expect_ev(EV_ERR_DN, 0, 0, cyc + 1);
      m_err = 1'b0;
    end
    send(8'hA5);
  endtask

  task automatic frame(input logic [7:0] delta, input int maxgap);
    int n;
    logic [7:0] l;
    logic [7:0] cs;
    n  = fw.size();
    l  = 8'(n);
    cs = l;
    foreach (fw[i]) cs ^= fw[i][15:8] ^ fw[i][7:0];
    sync_byte();
    gap($urandom_range(0, maxgap));
    send(l);
    gap($urandom_range(0, maxgap));
    foreach (fw[i]) begin
      send(fw[i][15:8]);
      gap($urandom_range(0, maxgap));
      expect_ev(EV_WR, i, int'(fw[i]), cyc + 1);
      send(fw[i][7:0]);
      gap($urandom_range(0, maxgap));
    end
    if (delta == 8'h00) begin
      expect_ev(EV_RUN_UP, n, 0, cyc + 1);
      m_run = 1'b1;
    end else begin
      expect_ev(EV_ERR_UP, 0, 0, cyc + 1);
      m_err = 1'b1;
    end
    send(cs ^ delta);
    gap(2);
    chk("cpu_run level", int'(cpu_run), int'(m_run));
    chk("load_err level", int'(load_err), int'(m_err));
  endtask

  task automatic rand_words(input int n);
    fw.delete();
    repeat (n) fw.push_back(16'($urandom));
  endtask

  initial begin
    #3;
    chk("reset mem_we", int'(mem_we), 0);
    chk("reset mem_waddr", int'(mem_waddr), 0);
    chk("reset mem_wdata", int'(mem_wdata), 0);
    chk("reset cpu_run", int'(cpu_run), 0);
    chk("reset load_err", int'(load_err), 0);
    chk("reset words_loaded", int'(words_loaded), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    gap(2);

    fw = '{16'h1234, 16'hABCD};
    frame(8'h00, 2);
    send(8'hA5);
    send(8'h03);
    gap(3);
    chk("run ignores rx", int'(cpu_run), 1);
    press_btn();
    chk("run press", int'(cpu_run), 0);

    fw = '{16'h1234, 16'hABCD};
    frame(8'h01, 1);
    fw = '{16'h0F0F};
    frame(8'h00, 1);
    press_btn();
    rand_words(3);
    frame(8'h5A, 2);
    press_btn();
    chk("press in err", int'(load_err), 1);

    sync_byte();
    send(8'h01);
    expect_ev(EV_ERR_UP, 0, 0, cyc + 1 + TO);
    send(8'h55);
    m_err = 1'b1;
    gap(TO + 10);

    sync_byte();
    send(8'h02);
    send(8'h77);
    press_btn();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    gap(3);
    chk("abort after hi err", int'(load_err), 0);
    chk("abort after hi run", int'(cpu_run), 0);

    sync_byte();
    send(8'h01);
    send(8'h66);
    n_but = 1'b0;
    send(8'h44);
    n_but = 1'b1;
    send(8'h23);
    gap(3);
    chk("coincident press run", int'(cpu_run), 0);

    for (int it = 0; it < 12; it++) begin
      if (m_run || $urandom_range(0, 3) == 0) press_btn();
      rand_words($urandom_range(1, 8));
      frame(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 3);
    end
    if (m_run) press_btn();

    rand_words(256);
    frame(8'h00, 0);
    press_btn();
    rand_words(2);
    frame(8'h00, 1);
    press_btn();

    sync_byte();
    send(8'h04);
    fw = '{16'hDEAD, 16'hBEEF};
    foreach (fw[i]) begin
      send(fw[i][15:8]);
      expect_ev(EV_WR, i, int'(fw[i]), cyc + 1);
      send(fw[i][7:0]);
    end
    send(8'h12);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async mem_we", int'(mem_we), 0);
    chk("async mem_waddr", int'(mem_waddr), 0);
    chk("async mem_wdata", int'(mem_wdata), 0);
    chk("async words_loaded", int'(words_loaded), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    m_err = 1'b0;
    m_run = 1'b0;
    gap(2);
    rand_words(5);
    frame(8'h00, 2);
    press_btn();

    s_send(8'hA5);
    s_send(8'h10);
    chk("small L=DEPTH", int'(s_load_err), 0);
    gap(TO + 5);
    chk("small timeout", int'(s_load_err), 1);
    s_send(8'hA5);
    chk("small sync clear", int'(s_load_err), 0);
    s_send(8'h20);
    chk("small oversize", int'(s_load_err), 1);
    s_send(8'hA5);
    s_send(8'h00);
    chk("small L=0", int'(s_load_err), 1);
    chk("small no write", int'(s_we_seen), 0);

    gap(5);
    chk("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
